// File: rtl/rcb_arb_pkg.sv
// Shared types and defaults for the per-RCB port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   t_rcb_arb_state  - host write FSM states
//   RCB_MAX_RD_BURST - default bound on read grants while a host write waits
//   RCB_RD_LAT       - default RCB RAM read latency (ram_en -> ram_rdata)
package rcb_arb_pkg;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_PEND  = 2'd1,
        W_ISSUE = 2'd2,
        W_DONE  = 2'd3
    } t_rcb_arb_state;

    localparam int RCB_MAX_RD_BURST = 8;
    localparam int RCB_RD_LAT       = 2;

endpackage

// File: rtl/rcb_rd_pipe.sv
// Valid/tag delay line matching the RCB RAM read latency.
// Latency: LAT cycles from in_vld/in_tag to out_vld/out_tag.
// Backpressure: none; every entry leaves after exactly LAT cycles.
//
// Ports:
//   clk, reset       - core clock, synchronous active-high reset (flushes all stages)
//   in_vld, in_tag   - read issued to the RAM this cycle and its lookup tag
//   out_vld, out_tag - read data is on ram_rdata this cycle, with its tag
module rcb_rd_pipe
    import rcb_arb_pkg::*;
#(
    parameter int LAT   = RCB_RD_LAT,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_vld,
    output logic [TAG_W-1:0] out_tag
);

    logic [LAT-1:0]   vld_q;
    logic [TAG_W-1:0] tag_q [LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld;
            tag_q[0] <= in_tag;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[LAT-1];
    assign out_tag = tag_q[LAT-1];

endmodule

// File: rtl/rcb_arb.sv
// Per-RCB port arbiter: shares one single-port RCB RAM between strategy lookups
// (reads) and host programming writes.
// Latency: lookup accept -> response in 1+RAM_RD_LAT cycles; host req -> ram_we in 2 cycles.
// Backpressure: lkp_req_ready drops only in the cycle a host write is granted; no response backpressure.
//
// Ports:
//   clk, reset                     - core clock, synchronous active-high reset
//   hpb_wr_req/addr/data/byte_en   - host write request (level, held until rcb_wr_done)
//   rcb_wr_done                    - one-cycle pulse once the host write is committed
//   lkp_req_valid/addr/tag/ready   - lookup read request, valid/ready handshake
//   lkp_rsp_valid/data/tag         - in-order lookup responses
//   ram_en/we/addr/wdata/be        - registered RAM drive
//   ram_rdata                      - RAM read data, RAM_RD_LAT cycles after a read enable
module rcb_arb
    import rcb_arb_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 128,
    parameter int BE_W         = DATA_W / 8,
    parameter int TAG_W        = 8,
    parameter int RAM_RD_LAT   = RCB_RD_LAT,
    parameter int MAX_RD_BURST = RCB_MAX_RD_BURST
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              hpb_wr_req,
    input  logic [ADDR_W-1:0] hpb_wr_addr,
    input  logic [DATA_W-1:0] hpb_wr_data,
    input  logic [BE_W-1:0]   hpb_wr_byte_en,
    output logic              rcb_wr_done,

    input  logic              lkp_req_valid,
    input  logic [ADDR_W-1:0] lkp_req_addr,
    input  logic [TAG_W-1:0]  lkp_req_tag,
    output logic              lkp_req_ready,

    output logic              lkp_rsp_valid,
    output logic [DATA_W-1:0] lkp_rsp_data,
    output logic [TAG_W-1:0]  lkp_rsp_tag,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [BE_W-1:0]   ram_be,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(MAX_RD_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RD_BURST);

    t_rcb_arb_state    state;
    t_rcb_arb_state    state_nxt;

    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic [BE_W-1:0]   hold_be;
    logic [CNT_W-1:0]  starve_cnt;

    logic              write_grant;
    logic              read_grant;

    logic              rd_vld_q;
    logic [TAG_W-1:0]  rd_tag_q;
    logic              pipe_vld;
    logic [TAG_W-1:0]  pipe_tag;

    // Arbitration and next-state. Lookups win unless the pending write has
    // already watched MAX_RD_BURST reads go ahead of it. Ready is gated by
    // reset so nothing is accepted while the block is being cleared.
    always_comb begin
        state_nxt     = state;
        write_grant   = 1'b0;
        lkp_req_ready = 1'b0;
        read_grant    = 1'b0;

        write_grant   = (state == W_PEND) && (!lkp_req_valid || (starve_cnt == CNT_MAX));
        lkp_req_ready = !reset && !write_grant;
        read_grant    = lkp_req_valid && lkp_req_ready;

        case (state)
            W_IDLE:  if (hpb_wr_req)  state_nxt = W_PEND;
            W_PEND:  if (write_grant) state_nxt = W_ISSUE;
            W_ISSUE: state_nxt = W_DONE;
            // Wait for the host to drop req so a held request is never re-issued.
            W_DONE:  if (!hpb_wr_req) state_nxt = W_IDLE;
            default: state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= W_IDLE;
            hold_addr   <= '0;
            hold_data   <= '0;
            hold_be     <= '0;
            starve_cnt  <= '0;
            rcb_wr_done <= 1'b0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            ram_be      <= '0;
            rd_vld_q    <= 1'b0;
            rd_tag_q    <= '0;
        end else begin
            state <= state_nxt;

            if ((state == W_IDLE) && hpb_wr_req) begin
                hold_addr <= hpb_wr_addr;
                hold_data <= hpb_wr_data;
                hold_be   <= hpb_wr_byte_en;
            end

            if ((state != W_PEND) || write_grant) begin
                starve_cnt <= '0;
            end else if (read_grant && (starve_cnt != CNT_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            // ram_we is high during W_ISSUE, so the commit pulse follows it.
            rcb_wr_done <= (state == W_ISSUE);

            ram_en <= read_grant || write_grant;
            ram_we <= write_grant;
            if (read_grant) begin
                ram_addr <= lkp_req_addr;
            end else if (write_grant) begin
                ram_addr  <= hold_addr;
                ram_wdata <= hold_data;
                ram_be    <= hold_be;
            end

            // First stage of the response tracker lines up with ram_en.
            rd_vld_q <= read_grant;
            if (read_grant) begin
                rd_tag_q <= lkp_req_tag;
            end
        end
    end

    rcb_rd_pipe #(
        .LAT   (RAM_RD_LAT),
        .TAG_W (TAG_W)
    ) u_rd_pipe (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (rd_vld_q),
        .in_tag  (rd_tag_q),
        .out_vld (pipe_vld),
        .out_tag (pipe_tag)
    );

    assign lkp_rsp_valid = pipe_vld;
    assign lkp_rsp_tag   = pipe_tag;
    // Data is zeroed outside a response so the bus is quiet after reset.
    assign lkp_rsp_data  = pipe_vld ? ram_rdata : '0;

endmodule

// File: tb/tb_rcb_arb.sv
// Bench for rcb_arb: RAM model with 2-cycle read latency, reference memory,
// and an in-order response scoreboard checking tag, data and arrival cycle.
module tb_rcb_arb;

    localparam int AW  = 16;
    localparam int DW  = 128;
    localparam int BW  = 16;
    localparam int TW  = 8;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          hpb_wr_req;
    logic [AW-1:0] hpb_wr_addr;
    logic [DW-1:0] hpb_wr_data;
    logic [BW-1:0] hpb_wr_byte_en;
    logic          rcb_wr_done;
    logic          lkp_req_valid;
    logic [AW-1:0] lkp_req_addr;
    logic [TW-1:0] lkp_req_tag;
    logic          lkp_req_ready;
    logic          lkp_rsp_valid;
    logic [DW-1:0] lkp_rsp_data;
    logic [TW-1:0] lkp_rsp_tag;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [BW-1:0] ram_be;
    logic [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    rcb_arb #(
        .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .TAG_W(TW),
        .RAM_RD_LAT(LAT), .MAX_RD_BURST(8)
    ) dut (
        .clk(clk), .reset(reset),
        .hpb_wr_req(hpb_wr_req), .hpb_wr_addr(hpb_wr_addr),
        .hpb_wr_data(hpb_wr_data), .hpb_wr_byte_en(hpb_wr_byte_en),
        .rcb_wr_done(rcb_wr_done),
        .lkp_req_valid(lkp_req_valid), .lkp_req_addr(lkp_req_addr),
        .lkp_req_tag(lkp_req_tag), .lkp_req_ready(lkp_req_ready),
        .lkp_rsp_valid(lkp_rsp_valid), .lkp_rsp_data(lkp_rsp_data),
        .lkp_rsp_tag(lkp_rsp_tag),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int i);
        return {4{32'hC0DE_0000 + 32'(i)}};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++) begin
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // RAM model (64 words) and reference image of what the host has committed.
    logic [DW-1:0] mem     [64];
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] rd_p1;
    logic [DW-1:0] rd_p2;
    assign ram_rdata = rd_p2;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        rd_p1 = '0;
        rd_p2 = '0;
    end

    always @(posedge clk) begin
        rd_p2 = rd_p1;
        if (ram_en) begin
            if (ram_we) mem[ram_addr[5:0]] = merge(mem[ram_addr[5:0]], ram_wdata, ram_be);
            else        rd_p1 = mem[ram_addr[5:0]];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: expectations pushed on accept, popped in order on response.
    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        int            due;
    } sb_t;
    sb_t sb_q[$];
    sb_t sb_e;
    sb_t sb_n;

    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
        end else begin
            if (lkp_rsp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", lkp_rsp_valid, 1'b0);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("rsp_tag",   lkp_rsp_tag,  sb_e.tag);
                    chk("rsp_data",  lkp_rsp_data, sb_e.data);
                    chk("rsp_cycle", cyc,          sb_e.due);
                end
            end
            if (lkp_req_valid && lkp_req_ready) begin
                sb_n.tag  = lkp_req_tag;
                sb_n.data = ref_mem[lkp_req_addr[5:0]];
                sb_n.due  = cyc + 1 + LAT;
                sb_q.push_back(sb_n);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Host write with the lookup path idle; called right after req is raised (cycle c0).
    task automatic wr_tail(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        tick();                         // c0+1: write granted
        lkp_req_valid = 1'b0;
        tick();                         // c0+2: write on the RAM port
        ref_mem[a[5:0]] = merge(ref_mem[a[5:0]], d, be);
        mid();
        chk("wr_ram_en",    ram_en,    1'b1);
        chk("wr_ram_we",    ram_we,    1'b1);
        chk("wr_ram_addr",  ram_addr,  a);
        chk("wr_ram_wdata", ram_wdata, d);
        chk("wr_ram_be",    ram_be,    be);
        tick();                         // c0+3: commit pulse
        mid();
        chk("wr_done_pulse", rcb_wr_done, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            mid();
            chk("wr_done_once", rcb_wr_done, 1'b0);
            chk("wr_no_reissue", ram_we, 1'b0);
        end
        tick();
        hpb_wr_req = 1'b0;
        tick();
    endtask

    logic exp_rdy;
    logic acc;
    int   tagc;

    initial begin
        reset          = 1'b1;
        hpb_wr_req     = 1'b1;
        hpb_wr_addr    = 16'h0020;
        hpb_wr_data    = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        hpb_wr_byte_en = 16'hFFFF;
        lkp_req_valid  = 1'b1;
        lkp_req_addr   = 16'h0003;
        lkp_req_tag    = 8'h11;

        // 1: reset held 3 edges with both requesters active
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready",    lkp_req_ready, 1'b0);
            chk("rst_rsp_vld",  lkp_rsp_valid, 1'b0);
            chk("rst_rsp_data", lkp_rsp_data,  '0);
            chk("rst_rsp_tag",  lkp_rsp_tag,   '0);
            chk("rst_done",     rcb_wr_done,   1'b0);
            chk("rst_ram_ctl",  {ram_en, ram_we}, 2'b00);
            chk("rst_ram_addr", ram_addr,  '0);
            chk("rst_ram_wd",   ram_wdata, '0);
            chk("rst_ram_be",   ram_be,    '0);
        end
        reset = 1'b0;
        mid();
        chk("t1_first_accept", lkp_req_ready, 1'b1);
        wr_tail(16'h0020, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 16'hFFFF);

        // 2: host write with the lookup path idle
        tick();
        hpb_wr_req     = 1'b1;
        hpb_wr_addr    = 16'h0010;
        hpb_wr_data    = {16{8'hA5}};
        hpb_wr_byte_en = 16'hFFFF;
        wr_tail(16'h0010, {16{8'hA5}}, 16'hFFFF);

        // 3: back-to-back lookups, full throughput
        for (int i = 0; i < 20; i++) begin
            tick();
            lkp_req_valid = 1'b1;
            lkp_req_addr  = AW'(i);
            lkp_req_tag   = TW'(i);
            mid();
            chk("t3_ready", lkp_req_ready, 1'b1);
        end
        tick();
        lkp_req_valid = 1'b0;
        repeat (5) tick();

        // 4: starvation guard, twice to show the counter restarts
        tagc = 100;
        for (int r = 0; r < 2; r++) begin
            tick();
            hpb_wr_req     = 1'b1;
            hpb_wr_addr    = AW'(16'h0030 + r);
            hpb_wr_data    = {8{16'hD400 + 16'(r)}};
            hpb_wr_byte_en = 16'hFFFF;
            acc = 1'b1;
            for (int j = 0; j < 15; j++) begin
                if (j > 0) tick();
                if (acc) begin
                    lkp_req_addr = AW'(tagc % 64);
                    lkp_req_tag  = TW'(tagc);
                    tagc++;
                end
                lkp_req_valid = 1'b1;
                if (j == 10) ref_mem[6'h30 + 6'(r)] = {8{16'hD400 + 16'(r)}};
                if (j == 12) hpb_wr_req = 1'b0;
                mid();
                exp_rdy = (j != 9);
                chk("t4_ready", lkp_req_ready, exp_rdy);
                acc = exp_rdy;
                if (j == 10) begin
                    chk("t4_ram_we",   ram_we,   1'b1);
                    chk("t4_ram_addr", ram_addr, AW'(16'h0030 + r));
                end
                if (j == 11) chk("t4_done", rcb_wr_done, 1'b1);
                if (j == 12) chk("t4_done_end", rcb_wr_done, 1'b0);
            end
        end
        tick();
        lkp_req_valid = 1'b0;
        repeat (5) tick();

        // 5: read-before / read-after ordering around a partial write to addr 5
        hpb_wr_req     = 1'b1;
        hpb_wr_addr    = 16'h0005;
        hpb_wr_data    = 128'hBEEF;
        hpb_wr_byte_en = 16'h0003;
        lkp_req_valid  = 1'b1;
        lkp_req_addr   = 16'h0005;
        lkp_req_tag    = 8'h50;
        mid();
        chk("t5_rdy_before", lkp_req_ready, 1'b1);
        tick();
        lkp_req_valid = 1'b0;
        tick();
        ref_mem[5] = merge(ref_mem[5], 128'hBEEF, 16'h0003);
        lkp_req_valid = 1'b1;
        lkp_req_tag   = 8'h51;
        mid();
        chk("t5_ram_we",    ram_we,        1'b1);
        chk("t5_rdy_after", lkp_req_ready, 1'b1);
        tick();
        lkp_req_valid = 1'b0;
        mid();
        chk("t5_done", rcb_wr_done, 1'b1);
        tick();
        hpb_wr_req = 1'b0;
        repeat (5) tick();

        // 6: reset with reads in flight and a write pending
        hpb_wr_req     = 1'b1;
        hpb_wr_addr    = 16'h003F;
        hpb_wr_data    = '1;
        hpb_wr_byte_en = 16'hFFFF;
        lkp_req_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            lkp_req_addr = AW'(k);
            lkp_req_tag  = TW'(8'h60 + k);
            mid();
            chk("t6_ready", lkp_req_ready, 1'b1);
        end
        tick();
        reset         = 1'b1;
        hpb_wr_req    = 1'b0;
        lkp_req_valid = 1'b0;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mid();
            chk("t6_no_rsp",   lkp_rsp_valid, 1'b0);
            chk("t6_no_done",  rcb_wr_done,   1'b0);
            chk("t6_no_ramen", ram_en,        1'b0);
            tick();
        end
        chk("t6_no_write", mem[63], init_val(63));
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, expected test to finish before it");
        $fatal(1);
    end

endmodule

// File: doc/rcb_arb.md
Name: rcb_arb

Overview:
- Per-RCB port arbiter. Shares one single-port RCB RAM between two requesters:
  - the strategy lookup path (reads, latency-critical);
  - the host programming path (writes arriving on the hpb_if handshake hpb_wr_req / rcb_wr_done).
- One instance sits behind each of the symbol, price, volume and order RCB RAMs.
- Lookups win by default. A starvation guard bounds how long a host write can wait.

Parameters:
- ADDR_W, 16, RAM word address width
- DATA_W, 128, RAM data width
- BE_W, DATA_W/8, byte-enable width
- TAG_W, 8, lookup tag width, returned unchanged with the response
- RAM_RD_LAT, 2, RAM read latency in cycles from ram_en to ram_rdata valid (must be >=1)
- MAX_RD_BURST, 8, max consecutive read grants while a write is pending (must be >=1)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- hpb_wr_req  in  1  host write request, level, held until rcb_wr_done is seen
- hpb_wr_addr  in  ADDR_W  host write address
- hpb_wr_data  in  DATA_W  host write data
- hpb_wr_byte_en  in  BE_W  host byte enables
- rcb_wr_done  out  1  one-cycle pulse when the host write is committed to RAM
- lkp_req_valid  in  1  lookup read request
- lkp_req_addr  in  ADDR_W  lookup address
- lkp_req_tag  in  TAG_W  lookup tag
- lkp_req_ready  out  1  lookup accepted when valid && ready
- lkp_rsp_valid  out  1  lookup response valid
- lkp_rsp_data  out  DATA_W  read data
- lkp_rsp_tag  out  TAG_W  tag of the returning lookup
- ram_en  out  1  RAM access enable, registered
- ram_we  out  1  RAM write enable, registered
- ram_addr  out  ADDR_W  RAM address, registered
- ram_wdata  out  DATA_W  RAM write data, registered
- ram_be  out  BE_W  RAM byte enables, registered
- ram_rdata  in  DATA_W  RAM read data, valid RAM_RD_LAT cycles after ram_en && !ram_we

Behaviour:

Reset (reset=1 at a clk edge):
- All outputs go to 0 and the write FSM goes to W_IDLE.
- starve_cnt is cleared.
- The read valid/tag pipeline is flushed; in-flight responses are dropped, never emitted.
- A host write that is pending but not yet issued is abandoned.

Write FSM (t_rcb_arb_state):
- W_IDLE: if hpb_wr_req=1, capture addr, data and byte_en into holding registers and go to W_PEND.
- W_PEND: wait for a write grant. On grant, go to W_ISSUE.
- W_ISSUE (the cycle in which ram_we=1 is driven): rcb_wr_done=1 on the next edge for exactly 1 cycle. Go to W_DONE.
- W_DONE: hold until hpb_wr_req=0, then go to W_IDLE. The write is never re-issued while req is still high.

Arbitration (combinational, evaluated every cycle):
- write_grant = (state==W_PEND) && (!lkp_req_valid || starve_cnt==MAX_RD_BURST).
- lkp_req_ready = !write_grant.
- read_grant = lkp_req_valid && lkp_req_ready.
- At most one grant per cycle. No bubble cycles are inserted.

Starve counter:
- starve_cnt increments on read_grant while state==W_PEND, saturating at MAX_RD_BURST.
- It clears on write_grant and whenever state!=W_PEND.

RAM drive (on the edge after a grant):
- read_grant: ram_en=1, ram_we=0, ram_addr=lkp_req_addr.
- write_grant: ram_en=1, ram_we=1; addr, wdata and be come from the holding registers.
- No grant: ram_en=0, ram_we=0. Addr/data hold their last values.

Read latency:
- A lookup accepted at cycle t gives lkp_rsp_valid=1 at cycle t+1+RAM_RD_LAT (default 3).
- lkp_rsp_data=ram_rdata and lkp_rsp_tag is the accepted tag.
- Responses return in order. There is no response backpressure; the consumer must always accept.

Ordering:
- A lookup accepted in any cycle after write_grant sees the new data. The single port serialises accesses, so no bypass is needed.
- A lookup accepted before write_grant sees the old data.

Simultaneous events:
- hpb_wr_req rising in the same cycle as lkp_req_valid: the request is captured that cycle and arbitration starts the following cycle.
- Back-to-back host writes: minimum spacing is set by the hpb_wr_req drop in W_DONE.

Decomposition:
- tts_pkg additions:
  - t_rcb_arb_state enum (W_IDLE, W_PEND, W_ISSUE, W_DONE);
  - RCB_MAX_RD_BURST default constant;
  - RCB_RD_LAT default constant.
- Sub-module rcb_rd_pipe: a RAM_RD_LAT-deep valid/tag delay line with synchronous flush on reset.

Test Plan:
1. Reset held 3 cycles with lkp_req_valid=1 and hpb_wr_req=1 -> all outputs 0 throughout. First read accept occurs on the first cycle after reset deasserts; the write is captured at that edge.
2. Idle lookup path, host write addr=0x0010, data=0xA5.., be=0xFFFF -> ram_we=1 with those values 2 cycles after the req rise. rcb_wr_done pulses 1 cycle later, and only once while req stays high.
3. Continuous lookups (tags 0..N) with RAM_RD_LAT=2 -> lkp_rsp_valid 3 cycles after each accept, tags in order, 100% throughput.
4. Continuous lookups plus a pending write, MAX_RD_BURST=8 -> exactly 8 read grants, then lkp_req_ready=0 for 1 cycle while the write issues, then reads resume. Counter is cleared.
5. Write 0xBEEF to addr 5, then lookup addr 5 on the cycle after write_grant -> response data 0xBEEF. A lookup of addr 5 accepted just before the grant -> old data.
6. Reset asserted with 2 reads in flight and the FSM in W_PEND -> no lkp_rsp_valid and no rcb_wr_done after reset, and no RAM write occurs.
